// File: rtl/bs_lsf_norm_if.sv
// ---------------------------------------------------------------------------
// bs_lsf_norm_if
//   Valid/ready bus for the normalizing left shifter.
//   Input side : in_valid / in_ready / in_a (signed operand)
//   Output side: out_valid / out_ready / out_c (normalized value),
//                out_shamt (applied left shift), out_zero (operand was 0)
//   master : the producer/consumer environment around the shifter
//   slave  : the shifter itself
// ---------------------------------------------------------------------------
interface bs_lsf_norm_if #(
    parameter int DW = 48,
    parameter int SW = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_a;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_c;
    logic        [SW-1:0] out_shamt;
    logic                 out_zero;

    modport master (
        output in_valid, in_a, out_ready,
        input  in_ready, out_valid, out_c, out_shamt, out_zero
    );

    modport slave (
        input  in_valid, in_a, out_ready,
        output in_ready, out_valid, out_c, out_shamt, out_zero
    );
endinterface

// File: rtl/bs_lsf_norm.sv
// ---------------------------------------------------------------------------
// bs_lsf_norm
//   Pipelined normalizing left shifter. Counts the redundant sign bits of a
//   signed operand, removes up to 2**SW-1 of them by shifting left, and
//   reports the shift so that (out_c >>> out_shamt) restores the operand.
//   Two-stage valid/ready pipeline with full backpressure, one result per
//   cycle, two cycles of latency when not stalled.
//
//   Ports:
//     clk    in  clock, all state on rising edge
//     rst_n  in  asynchronous active-low reset
//     bus    slave modport of bs_lsf_norm_if:
//              in_valid/in_ready/in_a           operand handshake
//              out_valid/out_ready              result handshake
//              out_c      normalized value = in_a << out_shamt
//              out_shamt  applied left shift, 0..2**SW-1
//              out_zero   operand was exactly zero
// ---------------------------------------------------------------------------
module bs_lsf_norm #(
    parameter int DW = 48,
    parameter int SW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    bs_lsf_norm_if.slave  bus
);

    localparam int CW     = $clog2(DW);
    localparam int SH_MAX = (1 << SW) - 1;

    typedef logic [CW-1:0] rs_t;

    // Number of bits below the MSB, scanning down from DW-2, that repeat the
    // sign bit; stops at the first bit that differs.
    function automatic rs_t count_rs(input logic signed [DW-1:0] a);
        rs_t  n;
        logic run;
        n   = '0;
        run = 1'b1;
        for (int i = DW - 2; i >= 0; i--) begin
            if (run && (a[i] == a[DW-1])) begin
                n = n + rs_t'(1);
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    // Clamp the redundant-sign count to the largest encodable shift.
    function automatic logic [SW-1:0] sat_shamt(input rs_t rs);
        if (int'(rs) > SH_MAX) begin
            return SW'(SH_MAX);
        end
        return SW'(rs);
    endfunction

    logic                 en1;
    logic                 en2;
    logic                 vld_p1;
    logic signed [DW-1:0] a_p1;
    logic        [SW-1:0] shamt_p1;
    logic                 zero_p1;

    // A stage may load when it is empty or when its contents move on this
    // cycle; in_ready follows out_ready combinationally so a full pipeline
    // keeps streaming without a bubble.
    assign en2          = !bus.out_valid || bus.out_ready;
    assign en1          = !vld_p1 || en2;
    assign bus.in_ready = en1;

    // ---- stage 1: capture operand, count and clamp redundant sign bits ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            a_p1     <= '0;
            shamt_p1 <= '0;
            zero_p1  <= 1'b0;
        end else if (en1) begin
            vld_p1   <= bus.in_valid;
            a_p1     <= bus.in_a;
            shamt_p1 <= sat_shamt(count_rs(bus.in_a));
            zero_p1  <= (bus.in_a == '0);
        end
    end

    // ---- stage 2: apply the shift; zero fill keeps the sign because only ----
    // ---- redundant copies of it are pushed out                           ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_c     <= '0;
            bus.out_shamt <= '0;
            bus.out_zero  <= 1'b0;
        end else if (en2) begin
            bus.out_valid <= vld_p1;
            bus.out_c     <= a_p1 << shamt_p1;
            bus.out_shamt <= shamt_p1;
            bus.out_zero  <= zero_p1;
        end
    end

endmodule
